// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DFLT = 5;
    localparam int DATA_W_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester A/B handshakes plus the RAM command bus, bundled for the arbiter.
interface ram_arbiter_if #(
    parameter int ADDR_W = ram_arb_pkg::ADDR_W_DFLT,
    parameter int DATA_W = ram_arb_pkg::DATA_W_DFLT
) ();

    logic              a_req, a_we, a_gnt, a_done;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata, a_rdata;
    logic              b_req, b_we, b_gnt, b_done;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata, b_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;

    // Requesters and the RAM model sit on the master side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_done, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_done, b_rdata,
        input  ram_we, ram_addr, ram_din,
        output ram_dout
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_done, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_done, b_rdata,
        output ram_we, ram_addr, ram_din,
        input  ram_dout
    );

endinterface

// File: rtl/ram_arbiter_rr.sv
// Combinational two-way round-robin picker: on a tie the port not served last wins.
module ram_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    assign any    = |req;
    assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for a single-port RAM with registered read.
// Optional done counters per port when RAM_ARBITER_STATS_EN is defined.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic        clock,
    input  logic        resetn,
`ifdef RAM_ARBITER_STATS_EN
    output logic [7:0]  a_count,
    output logic [7:0]  b_count,
`endif
    ram_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_ISSUE   = ISSUE;
    localparam logic [1:0] S_CAPTURE = CAPTURE;

    logic [1:0]              req, req_we;
    logic [1:0][ADDR_W-1:0]  req_addr;
    logic [1:0][DATA_W-1:0]  req_wdata;
    logic                    winner, any;

    logic [1:0]              state_q;
    logic                    last_q, cur_port_q, cur_we_q;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       din_q;
    logic [1:0]              gnt_q, done_q;
    logic [1:0][DATA_W-1:0]  rdata_q;

    assign req       = {bus.b_req, bus.a_req};
    assign req_we    = {bus.b_we, bus.a_we};
    assign req_addr  = {bus.b_addr, bus.a_addr};
    assign req_wdata = {bus.b_wdata, bus.a_wdata};

    ram_arb_rr u_rr (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    // gnt/done are single-cycle pulses; requests are only looked at in IDLE
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            last_q     <= PORT_B;
            cur_port_q <= PORT_A;
            cur_we_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    we_q <= 1'b0;
                    if (any) begin
                        we_q          <= req_we[winner];
                        addr_q        <= req_addr[winner];
                        din_q         <= req_wdata[winner];
                        gnt_q[winner] <= 1'b1;
                        last_q        <= winner;
                        cur_port_q    <= winner;
                        cur_we_q      <= req_we[winner];
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    we_q <= 1'b0;
                    if (cur_we_q) begin
                        done_q[cur_port_q] <= 1'b1;
                        state_q            <= S_IDLE;
                    end else begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    rdata_q[cur_port_q] <= bus.ram_dout;
                    done_q[cur_port_q]  <= 1'b1;
                    state_q             <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_we   = we_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_din  = din_q;
    assign bus.a_gnt    = gnt_q[PORT_A];
    assign bus.b_gnt    = gnt_q[PORT_B];
    assign bus.a_done   = done_q[PORT_A];
    assign bus.b_done   = done_q[PORT_B];
    assign bus.a_rdata  = rdata_q[PORT_A];
    assign bus.b_rdata  = rdata_q[PORT_B];

`ifdef RAM_ARBITER_STATS_EN
    logic [1:0][7:0] cnt_q;

    for (genvar p = 0; p < 2; p++) begin : g_cnt
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn)
                cnt_q[p] <= '0;
            else if (done_q[p] && cnt_q[p] != 8'hFF)
                cnt_q[p] <= cnt_q[p] + 8'd1;
        end
    end

    assign a_count = cnt_q[PORT_A];
    assign b_count = cnt_q[PORT_B];
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: driver feeds per-port command queues,
// a reference model predicts grants/dones/data, a negedge monitor compares.
module tb_ram_arbiter;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wd;
    } cmd_t;

    typedef struct {
        int         edge_n;
        int         port;
        logic       we;
        logic [7:0] rd;
    } exp_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    ram_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

`ifdef RAM_ARBITER_STATS_EN
    logic [7:0] a_count, b_count;
`endif

    ram_arbiter dut (
        .clock  (clock),
        .resetn (resetn),
`ifdef RAM_ARBITER_STATS_EN
        .a_count(a_count),
        .b_count(b_count),
`endif
        .bus    (bus)
    );

    // 32x8 RAM: synchronous write, registered read
    logic [7:0] mem [32];
    always @(posedge clock) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    logic [1:0] req = 2'b00;
    logic [1:0] we  = 2'b00;
    logic [4:0] addr [2];
    logic [7:0] wd   [2];
    assign bus.a_req   = req[0];
    assign bus.a_we    = we[0];
    assign bus.a_addr  = addr[0];
    assign bus.a_wdata = wd[0];
    assign bus.b_req   = req[1];
    assign bus.b_we    = we[1];
    assign bus.b_addr  = addr[1];
    assign bus.b_wdata = wd[1];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- driver ----------------
    cmd_t qa[$];
    cmd_t qb[$];
    int   waitc [2] = '{0, 0};

    task automatic push(input int p, input logic w, input int a, input int d);
        cmd_t c;
        c.we = w; c.addr = 5'(a); c.wd = 8'(d);
        if (p == 0) qa.push_back(c); else qb.push_back(c);
    endtask

    task automatic drive(input int p);
        cmd_t c;
        logic g;
        int   qs;
        if (!resetn) begin
            req[p] = 1'b0; waitc[p] = 0;
            return;
        end
        g = (p == 0) ? bus.a_gnt : bus.b_gnt;
        if (req[p]) begin
            if (g) begin
                if (p == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                req[p] = 1'b0; waitc[p] = 0;
            end else begin
                waitc[p]++;
                if (waitc[p] > 100) begin
                    fail_now(p == 0 ? "a_gnt_wait" : "b_gnt_wait");
                    if (p == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                    req[p] = 1'b0; waitc[p] = 0;
                end
            end
        end
        qs = (p == 0) ? qa.size() : qb.size();
        if (!req[p] && qs > 0) begin
            c = (p == 0) ? qa[0] : qb[0];
            req[p] = 1'b1; we[p] = c.we; addr[p] = c.addr; wd[p] = c.wd;
        end
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin addr[p] = '0; wd[p] = '0; end
        forever begin
            @(posedge clock);
            #1;
            for (int p = 0; p < 2; p++) drive(p);
        end
    end

    // ---------------- reference model + monitor ----------------
    // Model: one server, free again at free_edge; ties go to the port not served last.
    logic [1:0] s_req = 2'b00;
    logic [1:0] s_we  = 2'b00;
    logic [4:0] s_addr [2];
    logic [7:0] s_wd   [2];
    logic [7:0] mem_m  [32];
    logic [7:0] rd_m   [2];
    int         cnt_m  [2];
    exp_t       expq[$];
    int         free_edge = 1;
    logic       last_m = 1'b1;
    logic [1:0] m_gnt, m_done;
    logic       m_we;
    int         m_w;
    exp_t       m_e;

    initial begin
        forever begin
            @(negedge clock);
            if (!resetn) begin
                free_edge = cyc + 1;
                last_m    = 1'b1;
                expq.delete();
                for (int p = 0; p < 2; p++) begin rd_m[p] = 8'h00; cnt_m[p] = 0; end
            end else begin
                m_gnt = 2'b00; m_we = 1'b0;
                if (cyc >= free_edge && s_req != 2'b00) begin
                    m_w = (s_req == 2'b11) ? int'(!last_m) : int'(s_req[1]);
                    last_m = m_w[0];
                    m_gnt[m_w] = 1'b1;
                    m_e.port = m_w; m_e.we = s_we[m_w];
                    chk("ram_addr", int'(bus.ram_addr), int'(s_addr[m_w]));
                    if (s_we[m_w]) begin
                        mem_m[s_addr[m_w]] = s_wd[m_w];
                        m_we = 1'b1;
                        chk("ram_din", int'(bus.ram_din), int'(s_wd[m_w]));
                        m_e.edge_n = cyc + 1; m_e.rd = 8'h00;
                        free_edge = cyc + 2;
                    end else begin
                        m_e.edge_n = cyc + 2; m_e.rd = mem_m[s_addr[m_w]];
                        free_edge = cyc + 3;
                    end
                    expq.push_back(m_e);
                end
                chk("a_gnt", int'(bus.a_gnt), int'(m_gnt[0]));
                chk("b_gnt", int'(bus.b_gnt), int'(m_gnt[1]));
                chk("ram_we", int'(bus.ram_we), int'(m_we));
                m_done = 2'b00;
                if (expq.size() > 0 && expq[0].edge_n == cyc) begin
                    m_e = expq.pop_front();
                    m_done[m_e.port] = 1'b1;
                    if (!m_e.we) rd_m[m_e.port] = m_e.rd;
                end
                chk("a_done", int'(bus.a_done), int'(m_done[0]));
                chk("b_done", int'(bus.b_done), int'(m_done[1]));
                chk("a_rdata", int'(bus.a_rdata), int'(rd_m[0]));
                chk("b_rdata", int'(bus.b_rdata), int'(rd_m[1]));
`ifdef RAM_ARBITER_STATS_EN
                chk("a_count", int'(a_count), cnt_m[0]);
                chk("b_count", int'(b_count), cnt_m[1]);
                for (int p = 0; p < 2; p++)
                    if (m_done[p] && cnt_m[p] < 255) cnt_m[p]++;
`endif
            end
            s_req = req; s_we = we;
            for (int p = 0; p < 2; p++) begin s_addr[p] = addr[p]; s_wd[p] = wd[p]; end
        end
    end

    // ---------------- sequencer ----------------
    task automatic drain();
        int n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!(qa.size() == 0 && qb.size() == 0 && req == 2'b00 &&
                     expq.size() == 0 && cyc + 1 >= free_edge) && n < 3000);
        if (n >= 3000) fail_now("drain");
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        chk("rst_ram_we", int'(bus.ram_we), 0);
        chk("rst_ram_addr", int'(bus.ram_addr), 0);
        chk("rst_ram_din", int'(bus.ram_din), 0);
        chk("rst_gnt", int'({bus.b_gnt, bus.a_gnt}), 0);
        chk("rst_done", int'({bus.b_done, bus.a_done}), 0);
        chk("rst_rdata", int'({bus.b_rdata, bus.a_rdata}), 0);
        #2 resetn = 1'b1;

        // tie straight after reset: A first, then B
        push(0, 1'b1, 1, 8'h11);
        push(1, 1'b1, 2, 8'h22);
        drain();

        // continuous read contention: A,B,A,B,A,B
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, 1, 0);
            push(1, 1'b0, 2, 0);
        end
        drain();
        chk("tie_a_rdata", int'(bus.a_rdata), 8'h11);
        chk("tie_b_rdata", int'(bus.b_rdata), 8'h22);

        // single write then read on A
        push(0, 1'b1, 3, 8'h55);
        drain();
        push(0, 1'b0, 3, 0);
        drain();
        chk("a_rdata_55", int'(bus.a_rdata), 8'h55);

        // cross-port coherence at the top address
        push(1, 1'b1, 31, 8'hAA);
        drain();
        push(0, 1'b0, 31, 0);
        drain();
        chk("a_rdata_aa", int'(bus.a_rdata), 8'hAA);
        chk("b_rdata_kept", int'(bus.b_rdata), 8'h22);

        // reset while an A read is in ISSUE
        push(0, 1'b0, 3, 0);
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.a_gnt && n < 50);
        if (n >= 50) fail_now("a_gnt_before_reset");
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_ram_we", int'(bus.ram_we), 0);
        chk("mid_rst_a_gnt", int'(bus.a_gnt), 0);
        chk("mid_rst_a_done", int'(bus.a_done), 0);
        chk("mid_rst_ram_addr", int'(bus.ram_addr), 0);
        chk("mid_rst_a_rdata", int'(bus.a_rdata), 0);
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
        repeat (4) @(negedge clock);
        push(0, 1'b0, 3, 0);
        drain();
        chk("post_rst_a_rdata", int'(bus.a_rdata), 8'h55);

`ifdef RAM_ARBITER_STATS_EN
        for (int i = 0; i < 300; i++) push(0, 1'b1, $urandom_range(0, 31), $urandom_range(0, 255));
        drain();
        repeat (2) @(negedge clock);
        chk("a_count_sat", int'(a_count), 255);
        chk("b_count_zero", int'(b_count), 0);
`endif

        // fill every address, then random mixed traffic with idle gaps
        for (int i = 0; i < 32; i++) push(int'($urandom_range(0, 1)), 1'b1, i, $urandom_range(0, 255));
        drain();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < int'($urandom_range(1, 6)); i++)
                push(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 31), $urandom_range(0, 255));
            repeat ($urandom_range(0, 8)) @(negedge clock);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
